// File: rtl/axil_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : axil_data_mem
// Brief    : Byte-strobed block-RAM data memory behind an AXI4-Lite slave port
// Revision : 1.0 - initial release
// ============================================================================
module axil_data_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 256,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int         c_offs        = $clog2(STRB_WIDTH);
    localparam int         c_idx_w       = ADDR_WIDTH - c_offs;
    localparam int         c_dep_w       = $clog2(DEPTH);
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_RESP}         rstate_t;

    function automatic logic in_range(input logic [c_idx_w-1:0] idx);
        return 32'(idx) < 32'(DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write channel
    wstate_t               r_wstate;
    wstate_t               w_wstate_next;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  w_aw_held_next;
    logic                  w_w_held_next;
    logic [c_idx_w-1:0]    r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [1:0]            r_bresp;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_in_range;
    logic                  w_mem_we;

    // Read channel
    rstate_t               r_rstate;
    rstate_t               w_rstate_next;
    logic [c_idx_w-1:0]    w_ar_idx;
    logic                  w_ar_in_range;
    logic                  w_ar_hs;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    // Byte-offset bits carry no meaning for a word-wide memory.
    logic w_unused;
    assign w_unused = ^{s_awaddr[c_offs-1:0], s_araddr[c_offs-1:0]};

    // Handshake-facing outputs are gated by rst so they read 0 throughout reset.
    assign s_awready = rst && (r_wstate == W_IDLE) && !r_aw_held;
    assign s_wready  = rst && (r_wstate == W_IDLE) && !r_w_held;
    assign s_bvalid  = rst && (r_wstate == W_RESP);
    assign s_bresp   = r_bresp;
    assign s_arready = rst && (r_rstate == R_IDLE) && (r_wstate != W_EXEC);
    assign s_rvalid  = rst && (r_rstate == R_RESP);
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

    assign w_aw_hs       = s_awvalid && s_awready;
    assign w_w_hs        = s_wvalid && s_wready;
    assign w_ar_hs       = s_arvalid && s_arready;
    assign w_aw_in_range = in_range(r_aw_idx);
    assign w_ar_idx      = s_araddr[ADDR_WIDTH-1:c_offs];
    assign w_ar_in_range = in_range(w_ar_idx);
    assign w_mem_we      = rst && (r_wstate == W_EXEC) && w_aw_in_range;

    always_comb begin
        w_wstate_next  = r_wstate;
        w_aw_held_next = r_aw_held;
        w_w_held_next  = r_w_held;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) w_aw_held_next = 1'b1;
                if (w_w_hs)  w_w_held_next  = 1'b1;
                if (w_aw_held_next && w_w_held_next) w_wstate_next = W_EXEC;
            end
            W_EXEC: begin
                w_aw_held_next = 1'b0;
                w_w_held_next  = 1'b0;
                w_wstate_next  = W_RESP;
            end
            W_RESP: begin
                if (s_bready) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= c_resp_okay;
        end else begin
            r_wstate  <= w_wstate_next;
            r_aw_held <= w_aw_held_next;
            r_w_held  <= w_w_held_next;
            if (w_aw_hs) r_aw_idx <= s_awaddr[ADDR_WIDTH-1:c_offs];
            if (w_w_hs) begin
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end
            if (r_wstate == W_EXEC)
                r_bresp <= w_aw_in_range ? c_resp_okay : c_resp_slverr;
        end
    end

    // Single RAM port: writes only in W_EXEC, and AR is refused in that cycle.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (r_wstrb[i])
                    r_mem[r_aw_idx[c_dep_w-1:0]][i*8 +: 8] <= r_wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)  w_rstate_next = R_RESP;
            R_RESP:  if (s_rready) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // RAM output register loads only on AR handshake, keeping R stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= c_resp_okay;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_rdata <= w_ar_in_range ? r_mem[w_ar_idx[c_dep_w-1:0]] : '0;
                r_rresp <= w_ar_in_range ? c_resp_okay : c_resp_slverr;
            end
        end
    end

endmodule
`default_nettype wire
